// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared types and constants for the instruction fetch front end
package cpu_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hbfc00000;
  localparam int unsigned FETCH_WORD_BYTES     = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/cpu_fetch_queue_if.sv
// rtl/cpu_fetch_queue_if.sv - instruction bus, decode handshake and redirect signals
interface cpu_fetch_queue_if;

  logic [31:0] ibus_address;
  logic        ibus_read;
  logic [31:0] ibus_data;
  logic        ibus_stall;
  logic        ibus_error;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_address;
  logic [31:0] out_instruction;
  logic        out_error;

  logic        branch_valid;
  logic [31:0] branch_inst_addr;
  logic [31:0] branch_address;

  // fetch queue side
  modport master (
    output ibus_address, ibus_read,
    input  ibus_data, ibus_stall, ibus_error,
    output out_valid, out_address, out_instruction, out_error,
    input  out_ready,
    input  branch_valid, branch_inst_addr, branch_address
  );

  // bus, decode and branch unit side
  modport slave (
    input  ibus_address, ibus_read,
    output ibus_data, ibus_stall, ibus_error,
    input  out_valid, out_address, out_instruction, out_error,
    output out_ready,
    output branch_valid, branch_inst_addr, branch_address
  );

endinterface

// File: rtl/cpu_fetch_fifo.sv
// rtl/cpu_fetch_fifo.sv - circular queue of fetched words with flush that can keep the head
module cpu_fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_entry,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic                   i_flush_keep_head,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;

  logic          w_pop;
  logic [AW-1:0] w_wr_base;
  logic [AW:0]   w_count_base;

  // a flush collapses the queue to at most the head; a same-cycle push lands right behind it
  assign w_pop        = i_pop && !i_flush && (r_count != '0);
  assign w_wr_base    = i_flush ? r_rd + AW'(i_flush_keep_head) : r_wr;
  assign w_count_base = i_flush ? (AW+1)'(i_flush_keep_head) : r_count;

  // entry storage
  always_ff @(posedge clock) begin
    if (i_push) r_mem[w_wr_base] <= i_push_entry;
  end

  // read/write pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_rd    <= r_rd + AW'(w_pop);
      r_wr    <= w_wr_base + AW'(i_push);
      r_count <= w_count_base + (AW+1)'(i_push) - (AW+1)'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/cpu_fetch_queue.sv
// rtl/cpu_fetch_queue.sv - sequential fetch issue, in-flight tracking and branch redirect
module cpu_fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          DEPTH        = 4
) (
  input logic               clock,
  input logic               reset,
  cpu_fetch_queue_if.master bus
);

  localparam int          CW   = $clog2(DEPTH) + 1;
  localparam logic [31:0] STEP = 32'(FETCH_WORD_BYTES);

  // presented request
  logic [31:0] r_addr;
  logic        r_read;
  logic        r_req_drop;    // presented request is stale: drop its response
  // accepted request awaiting its response
  logic        r_inf_valid;
  logic [31:0] r_inf_addr;
  logic        r_inf_drop;
  // redirect recorded during a stall, loaded at the first free cycle
  logic        r_ld;
  logic [31:0] r_ld_addr;
  // target to fetch once the delay slot request has been accepted
  logic        r_chain;
  logic [31:0] r_chain_addr;

  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;
  logic          w_nonempty, w_stall, w_acc, w_resp, w_branch;
  logic [31:0]   w_ds, w_first;
  logic          w_ds_queued, w_ds_inf, w_ds_req, w_ds_have;
  logic          w_push, w_pop, w_read_next;

  assign w_stall    = bus.ibus_stall;
  assign w_branch   = bus.branch_valid;
  assign w_nonempty = (w_count != '0);
  assign w_acc      = r_read && !w_stall;
  assign w_resp     = r_inf_valid && !w_stall;

  // delay slot may be at the queue head, in flight, or be the request the bus is holding;
  // only the first of these counts so it is never delivered twice
  assign w_ds        = bus.branch_inst_addr + STEP;
  assign w_ds_queued = w_nonempty && (w_head.addr == w_ds);
  assign w_ds_inf    = r_inf_valid && !r_inf_drop && (r_inf_addr == w_ds) && !w_ds_queued;
  assign w_ds_req    = r_read && !r_req_drop && (r_addr == w_ds) && !w_ds_queued && !w_ds_inf;
  assign w_ds_have   = w_ds_queued || w_ds_inf || w_ds_req;
  assign w_first     = w_ds_have ? bus.branch_address : w_ds;

  assign w_push_entry = '{addr: r_inf_addr, data: bus.ibus_data, err: bus.ibus_error};
  assign w_push       = w_resp && !r_inf_drop && (!w_branch || w_ds_inf);
  assign w_pop        = bus.out_valid && bus.out_ready;

  // issue gate looks at occupancy and in-flight as they will be after this edge
  assign w_count_next = (w_branch ? CW'(w_ds_queued) : w_count) + CW'(w_push) - CW'(w_pop);
  assign w_read_next  = (int'(w_count_next) + int'(w_acc)) < DEPTH;

  cpu_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock             (clock),
    .reset             (reset),
    .i_push            (w_push),
    .i_push_entry      (w_push_entry),
    .i_pop             (w_pop),
    .i_flush           (w_branch),
    .i_flush_keep_head (w_ds_queued),
    .o_head            (w_head),
    .o_count           (w_count)
  );

  // bus request, in-flight and redirect control; everything bus-facing holds while stalled
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr       <= RESET_VECTOR;
      r_read       <= 1'b1;
      r_req_drop   <= 1'b0;
      r_inf_valid  <= 1'b0;
      r_inf_addr   <= '0;
      r_inf_drop   <= 1'b0;
      r_ld         <= 1'b0;
      r_ld_addr    <= '0;
      r_chain      <= 1'b0;
      r_chain_addr <= '0;
    end else if (!w_stall) begin
      r_read      <= w_read_next;
      r_inf_valid <= w_acc;
      r_inf_addr  <= r_addr;
      r_inf_drop  <= w_branch ? !w_ds_req : r_req_drop;
      r_req_drop  <= 1'b0;
      r_ld        <= 1'b0;
      if (w_branch) begin
        r_addr       <= w_first;
        r_chain      <= !w_ds_have;
        r_chain_addr <= bus.branch_address;
      end else if (r_ld) begin
        r_addr <= r_ld_addr;
      end else if (w_acc) begin
        if (r_chain) begin
          r_addr  <= r_chain_addr;
          r_chain <= 1'b0;
        end else begin
          r_addr <= r_addr + STEP;
        end
      end
    end else if (w_branch) begin
      r_ld         <= 1'b1;
      r_ld_addr    <= w_first;
      r_chain      <= !w_ds_have;
      r_chain_addr <= bus.branch_address;
      r_req_drop   <= !w_ds_req;
      r_inf_drop   <= !w_ds_inf;
    end
  end

  assign bus.ibus_address    = r_addr;
  assign bus.ibus_read       = r_read;
  assign bus.out_valid       = w_nonempty && !w_branch;
  assign bus.out_address     = w_nonempty ? w_head.addr : '0;
  assign bus.out_instruction = w_nonempty ? w_head.data : '0;
  assign bus.out_error       = w_nonempty && w_head.err;

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// tb/tb_cpu_fetch_queue.sv - directed bench for cpu_fetch_queue
module tb_cpu_fetch_queue;
  import cpu_fetch_pkg::*;

  localparam logic [31:0] RV = 32'hbfc00000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cpu_fetch_queue_if bus_if ();

  cpu_fetch_queue #(.RESET_VECTOR(RV), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5a5a0f0f;
  endfunction

  logic [31:0] err_addr = RV + 32'h8;
  logic        m_take = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] del_addr[$];
  logic [31:0] del_data[$];
  logic        del_err[$];
  logic [31:0] req_addr[$];

  // bus observation and decode-side log, sampled mid-cycle
  always @(negedge clock) begin
    m_take = !bus_if.ibus_stall;
    m_addr = bus_if.ibus_address;
    if (!reset) begin
      if (bus_if.ibus_read && !bus_if.ibus_stall) req_addr.push_back(bus_if.ibus_address);
      if (bus_if.out_valid && bus_if.out_ready) begin
        del_addr.push_back(bus_if.out_address);
        del_data.push_back(bus_if.out_instruction);
        del_err.push_back(bus_if.out_error);
      end
    end
  end

  // memory answers the request accepted in the previous unstalled cycle
  always @(posedge clock) begin
    #1;
    if (m_take) begin
      bus_if.ibus_data  = mem_word(m_addr);
      bus_if.ibus_error = (m_addr == err_addr);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    del_addr.delete();
    del_data.delete();
    del_err.delete();
    req_addr.delete();
  endtask

  task automatic do_reset(input logic ready);
    reset = 1'b1;
    bus_if.out_ready    = ready;
    bus_if.branch_valid = 1'b0;
    bus_if.ibus_stall   = 1'b0;
    tick(2);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic branch(input logic [31:0] inst, input logic [31:0] target);
    bus_if.branch_valid     = 1'b1;
    bus_if.branch_inst_addr = inst;
    bus_if.branch_address   = target;
    clear_logs();
  endtask

  function automatic logic [31:0] del_at(input int i);
    return (i < del_addr.size()) ? del_addr[i] : 32'hdeadbeef;
  endfunction

  function automatic logic [31:0] req_at(input int i);
    return (i < req_addr.size()) ? req_addr[i] : 32'hdeadbeef;
  endfunction

  initial begin
    bit found;
    reset                   = 1'b1;
    bus_if.ibus_data        = '0;
    bus_if.ibus_error       = 1'b0;
    bus_if.ibus_stall       = 1'b0;
    bus_if.out_ready        = 1'b1;
    bus_if.branch_valid     = 1'b0;
    bus_if.branch_inst_addr = '0;
    bus_if.branch_address   = '0;

    // reset values
    tick(3);
    @(negedge clock);
    check("rst_addr", bus_if.ibus_address, RV);
    check("rst_read", bus_if.ibus_read, 1);
    check("rst_valid", bus_if.out_valid, 0);
    check("rst_oaddr", bus_if.out_address, 0);
    check("rst_oinst", bus_if.out_instruction, 0);
    check("rst_oerr", bus_if.out_error, 0);

    // streaming: latency, throughput, error tagging of RV+8
    tick(1);
    reset = 1'b0;
    clear_logs();
    @(negedge clock);
    check("c1_valid", bus_if.out_valid, 0);
    tick(1);
    @(negedge clock);
    check("c2_valid", bus_if.out_valid, 0);
    tick(1);
    @(negedge clock);
    check("c3_valid", bus_if.out_valid, 1);
    check("c3_addr", bus_if.out_address, RV);
    check("c3_inst", bus_if.out_instruction, mem_word(RV));
    for (int k = 4; k <= 8; k++) begin
      tick(1);
      @(negedge clock);
      check("stream_valid", bus_if.out_valid, 1);
    end
    #1;
    check("stream_ndel", del_addr.size(), 6);
    check("stream_nreq", req_addr.size(), 8);
    check("stream_req7", req_at(7), RV + 32'h1c);
    for (int i = 0; i < 6; i++) begin
      check("stream_addr", del_at(i), RV + 32'(4 * i));
      if (i < del_data.size()) check("stream_data", del_data[i], mem_word(RV + 32'(4 * i)));
      if (i < del_err.size()) check("stream_err", del_err[i], (i == 2) ? 1 : 0);
    end

    // backpressure: exactly DEPTH requests, then in-order drain and resume
    tick(1);
    do_reset(1'b0);
    tick(9);
    @(negedge clock);
    check("bp_read", bus_if.ibus_read, 0);
    check("bp_valid", bus_if.out_valid, 1);
    check("bp_head", bus_if.out_address, RV);
    #1;
    check("bp_nreq", req_addr.size(), 4);
    check("bp_req3", req_at(3), RV + 32'hc);
    tick(1);
    bus_if.out_ready = 1'b1;
    clear_logs();
    tick(9);
    @(negedge clock);
    #1;
    check("bp_ndel", del_addr.size(), 10);
    for (int i = 0; i < 10; i++) check("bp_order", del_at(i), RV + 32'(4 * i));

    // branch at 0x10 with its delay slot at the queue head
    tick(1);
    do_reset(1'b1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus_if.out_valid && bus_if.out_address == RV + 32'h10) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    check("dsq_sync", found, 1);
    tick(1);
    branch(RV + 32'h10, RV + 32'h100);
    @(negedge clock);
    check("dsq_bubble", bus_if.out_valid, 0);
    tick(1);
    bus_if.branch_valid = 1'b0;
    @(negedge clock);
    check("dsq_target", bus_if.ibus_address, RV + 32'h100);
    tick(6);
    @(negedge clock);
    #1;
    check("dsq_del0", del_at(0), RV + 32'h14);
    check("dsq_del1", del_at(1), RV + 32'h100);
    check("dsq_del2", del_at(2), RV + 32'h104);

    // same branch with the delay slot not yet fetched (queue full of older words)
    tick(1);
    do_reset(1'b0);
    tick(9);
    branch(RV + 32'h10, RV + 32'h100);
    bus_if.out_ready = 1'b1;
    @(negedge clock);
    check("dsn_bubble", bus_if.out_valid, 0);
    tick(1);
    bus_if.branch_valid = 1'b0;
    @(negedge clock);
    check("dsn_ds_addr", bus_if.ibus_address, RV + 32'h14);
    tick(8);
    @(negedge clock);
    #1;
    check("dsn_req0", req_at(0), RV + 32'h14);
    check("dsn_req1", req_at(1), RV + 32'h100);
    check("dsn_req2", req_at(2), RV + 32'h104);
    check("dsn_del0", del_at(0), RV + 32'h14);
    check("dsn_del1", del_at(1), RV + 32'h100);
    check("dsn_del2", del_at(2), RV + 32'h104);

    // branch during a three-cycle stall; stale requests are dropped
    tick(1);
    do_reset(1'b1);
    tick(5);
    bus_if.ibus_stall = 1'b1;
    @(negedge clock);
    check("stl_hold1", bus_if.ibus_address, RV + 32'h14);
    tick(1);
    branch(RV + 32'h200, RV + 32'h300);
    @(negedge clock);
    check("stl_hold2", bus_if.ibus_address, RV + 32'h14);
    tick(1);
    bus_if.branch_valid = 1'b0;
    @(negedge clock);
    check("stl_hold3", bus_if.ibus_address, RV + 32'h14);
    tick(1);
    bus_if.ibus_stall = 1'b0;
    tick(1);
    @(negedge clock);
    check("stl_redir", bus_if.ibus_address, RV + 32'h204);
    tick(6);
    @(negedge clock);
    #1;
    check("stl_req0", req_at(0), RV + 32'h14);
    check("stl_req1", req_at(1), RV + 32'h204);
    check("stl_req2", req_at(2), RV + 32'h300);
    check("stl_del0", del_at(0), RV + 32'h204);
    check("stl_del1", del_at(1), RV + 32'h300);
    check("stl_del2", del_at(2), RV + 32'h304);
    if (del_data.size() > 0) check("stl_data0", del_data[0], mem_word(RV + 32'h204));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
